// File: rtl/sprite_line_engine.sv
// Double-buffered scanline sprite renderer: renders line N+1 into the back
// buffer from ROM texels while line N is shown from the front buffer.
module sprite_line_engine #(
    parameter int          NUM_SPRITES = 8,
    parameter int          NUM_IDS     = 4,
    parameter int          ADDR_W      = 14,
    parameter int          H_ACTIVE    = 640,
    parameter int          V_ACTIVE    = 480,
    parameter int          V_TOTAL     = 525,
    parameter logic [23:0] TRANSPARENT = 24'hFF00FF,
    parameter logic [23:0] BG_COLOR    = 24'h000000
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [32*NUM_SPRITES-1:0]     sprite_attr,
    input  logic [9:0]                    VGA_HCOUNT,
    input  logic [9:0]                    VGA_VCOUNT,
    output logic [ADDR_W*NUM_IDS-1:0]     rom_addr,
    input  logic [24*NUM_IDS-1:0]         rom_data,
    output logic [7:0]                    VGA_R,
    output logic [7:0]                    VGA_G,
    output logic [7:0]                    VGA_B,
    output logic                          line_overflow
);

    localparam int KW = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
    localparam int HW = $clog2(H_ACTIVE);

    typedef enum logic [1:0] {IDLE, SCAN, FETCH, DRAIN} state_t;

    state_t               state_q, state_d;
    logic [KW-1:0]        k_q, k_d;
    logic [6:0]           row_q, row_d;
    logic [6:0]           col_q, col_d;
    logic [9:0]           target_q, target_d;
    logic [9:0]           vcount_q;
    logic                 front_q, front_d;
    logic [H_ACTIVE-1:0]  valid0_q, valid0_d;
    logic [H_ACTIVE-1:0]  valid1_q, valid1_d;
    logic                 wr_vld_p1_q, wr_vld_p1_d;
    logic [10:0]          wr_px_p1_q, wr_px_p1_d;
    logic [4:0]           wr_id_p1_q, wr_id_p1_d;
    logic [23:0]          rgb_q, rgb_d;
    logic                 ovf_q, ovf_d;

    logic [31:0]          attr_q [NUM_SPRITES];
    logic [31:0]          attr_d [NUM_SPRITES];
    logic [23:0]          buf0_q [H_ACTIVE];
    logic [23:0]          buf1_q [H_ACTIVE];

    logic                 line_start;
    logic [9:0]           next_target;
    logic [31:0]          cur_attr;
    logic [6:0]           cur_dim;
    logic [4:0]           cur_id;
    logic [9:0]           cur_y;
    logic [9:0]           cur_x;
    logic                 cur_hit;
    logic                 last_k;
    logic [13:0]          texel_idx;

    logic [23:0]          wr_rgb;
    logic                 wr_in_range;
    logic [HW-1:0]        wr_idx;
    logic [H_ACTIVE-1:0]  back_valid;
    logic                 wr_en;

    logic                 h_in;
    logic [HW-1:0]        h_idx;
    logic [H_ACTIVE-1:0]  front_valid;
    logic [23:0]          front_pix;

    // Vertical extent test in 11 bits so y+dim-1 never wraps past 1023.
    function automatic logic sprite_hits(input logic [6:0] dim, input logic [4:0] id,
                                         input logic [9:0] y, input logic [9:0] line);
        logic [10:0] top;
        logic [10:0] bot;
        logic [10:0] ln;
        top = {1'b0, y};
        bot = top + {4'd0, dim} - 11'd1;
        ln  = {1'b0, line};
        return (dim != 7'd0) && (32'(id) < NUM_IDS) && (ln >= top) && (ln <= bot);
    endfunction

    assign line_start  = (VGA_VCOUNT != vcount_q);
    assign next_target = (VGA_VCOUNT == 10'(V_TOTAL - 1)) ? 10'd0 : VGA_VCOUNT + 10'd1;

    assign cur_attr  = attr_q[k_q];
    assign cur_dim   = cur_attr[31:25];
    assign cur_id    = cur_attr[24:20];
    assign cur_y     = cur_attr[19:10];
    assign cur_x     = cur_attr[9:0];
    assign cur_hit   = sprite_hits(cur_dim, cur_id, cur_y, target_q);
    assign last_k    = (k_q == KW'(NUM_SPRITES - 1));
    assign texel_idx = 14'(row_q) * 14'(cur_dim) + 14'(col_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A new line always wins: whatever sprites remain are abandoned.
    always_comb begin : fsm_next
        state_d  = state_q;
        k_d      = k_q;
        row_d    = row_q;
        col_d    = col_q;
        target_d = target_q;
        if (line_start) begin
            target_d = next_target;
            k_d      = '0;
            state_d  = (32'(next_target) < V_ACTIVE) ? SCAN : IDLE;
        end else begin
            case (state_q)
                SCAN: begin
                    if (cur_hit) begin
                        row_d   = 7'({1'b0, target_q} - {1'b0, cur_y});
                        col_d   = 7'd0;
                        state_d = FETCH;
                    end else if (last_k) begin
                        state_d = IDLE;
                    end else begin
                        k_d = k_q + KW'(1);
                    end
                end
                FETCH: begin
                    if (col_q == cur_dim - 7'd1) begin
                        state_d = DRAIN;
                    end else begin
                        col_d = col_q + 7'd1;
                    end
                end
                DRAIN: begin
                    if (last_k) begin
                        state_d = IDLE;
                    end else begin
                        k_d     = k_q + KW'(1);
                        state_d = SCAN;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin : fsm_out
        rom_addr = '0;
        if (state_q == FETCH) begin
            for (int i = 0; i < NUM_IDS; i++) begin
                if (cur_id == 5'(i)) begin
                    rom_addr[i*ADDR_W +: ADDR_W] = ADDR_W'(texel_idx);
                end
            end
        end
    end

    always_comb begin : datapath
        for (int s = 0; s < NUM_SPRITES; s++) begin
            attr_d[s] = line_start ? sprite_attr[32*s +: 32] : attr_q[s];
        end

        // Texel address issued in FETCH returns one clk later from the ROM.
        wr_vld_p1_d = (state_q == FETCH) && !line_start;
        wr_px_p1_d  = {1'b0, cur_x} + {4'd0, col_q};
        wr_id_p1_d  = cur_id;

        wr_rgb = 24'd0;
        for (int i = 0; i < NUM_IDS; i++) begin
            if (wr_id_p1_q == 5'(i)) begin
                wr_rgb = rom_data[24*i +: 24];
            end
        end
        wr_in_range = (32'(wr_px_p1_q) < H_ACTIVE);
        wr_idx      = wr_in_range ? HW'(wr_px_p1_q) : '0;
        back_valid  = front_q ? valid0_q : valid1_q;
        wr_en       = wr_vld_p1_q && wr_in_range && (wr_rgb != TRANSPARENT) && !back_valid[wr_idx];

        valid0_d = valid0_q;
        valid1_d = valid1_q;
        if (wr_en) begin
            if (front_q) begin
                valid0_d[wr_idx] = 1'b1;
            end else begin
                valid1_d[wr_idx] = 1'b1;
            end
        end
        // The old front becomes the new back and starts empty.
        if (line_start) begin
            if (front_q) begin
                valid1_d = '0;
            end else begin
                valid0_d = '0;
            end
        end
        front_d = line_start ? ~front_q : front_q;
        ovf_d   = line_start && (state_q != IDLE);

        h_in        = (32'(VGA_HCOUNT) < H_ACTIVE);
        h_idx       = h_in ? VGA_HCOUNT[HW-1:0] : '0;
        front_valid = front_q ? valid1_q : valid0_q;
        front_pix   = front_q ? buf1_q[h_idx] : buf0_q[h_idx];
        if (!h_in) begin
            rgb_d = 24'd0;
        end else if (!front_valid[h_idx]) begin
            rgb_d = BG_COLOR;
        end else begin
            rgb_d = front_pix;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            k_q         <= '0;
            row_q       <= '0;
            col_q       <= '0;
            target_q    <= '0;
            vcount_q    <= '0;
            front_q     <= 1'b0;
            valid0_q    <= '0;
            valid1_q    <= '0;
            wr_vld_p1_q <= 1'b0;
            rgb_q       <= '0;
            ovf_q       <= 1'b0;
        end else begin
            k_q         <= k_d;
            row_q       <= row_d;
            col_q       <= col_d;
            target_q    <= target_d;
            vcount_q    <= VGA_VCOUNT;
            front_q     <= front_d;
            valid0_q    <= valid0_d;
            valid1_q    <= valid1_d;
            wr_vld_p1_q <= wr_vld_p1_d;
            rgb_q       <= rgb_d;
            ovf_q       <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int s = 0; s < NUM_SPRITES; s++) begin
            attr_q[s] <= attr_d[s];
        end
        wr_px_p1_q <= wr_px_p1_d;
        wr_id_p1_q <= wr_id_p1_d;
        if (wr_en) begin
            if (front_q) begin
                buf0_q[wr_idx] <= wr_rgb;
            end else begin
                buf1_q[wr_idx] <= wr_rgb;
            end
        end
    end

    assign VGA_R         = rgb_q[23:16];
    assign VGA_G         = rgb_q[15:8];
    assign VGA_B         = rgb_q[7:0];
    assign line_overflow = ovf_q;

endmodule

// File: tb/tb_sprite_line_engine.sv
// Directed and randomized bench for sprite_line_engine with a per-pixel
// reference model derived from sprite geometry and priority rules.
module tb_sprite_line_engine;

    localparam int          NS = 16;
    localparam int          NI = 4;
    localparam int          AW = 14;
    localparam int          HA = 640;
    localparam int          VA = 480;
    localparam int          VT = 525;
    localparam logic [23:0] TR = 24'hFF00FF;
    localparam logic [23:0] BG = 24'h000000;

    logic              clk = 1'b0;
    logic              reset;
    logic [32*NS-1:0]  sprite_attr;
    logic [9:0]        hc;
    logic [9:0]        vc;
    logic [AW*NI-1:0]  rom_addr;
    logic [24*NI-1:0]  rom_data;
    logic [7:0]        vga_r, vga_g, vga_b;
    logic              ovf;

    int errors = 0;
    int checks = 0;
    int ovf_cnt = 0;
    int addr_cnt = 0;
    bit rom1_t3 = 1'b0;

    logic [32*NS-1:0]  shown_attr, pend_attr;
    int                shown_line, pend_line;

    sprite_line_engine #(
        .NUM_SPRITES(NS), .NUM_IDS(NI), .ADDR_W(AW), .H_ACTIVE(HA),
        .V_ACTIVE(VA), .V_TOTAL(VT), .TRANSPARENT(TR), .BG_COLOR(BG)
    ) dut (
        .clk(clk), .reset(reset), .sprite_attr(sprite_attr),
        .VGA_HCOUNT(hc), .VGA_VCOUNT(vc), .rom_addr(rom_addr), .rom_data(rom_data),
        .VGA_R(vga_r), .VGA_G(vga_g), .VGA_B(vga_b), .line_overflow(ovf)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] rom_word(int id, int addr);
        if (id == 1 && rom1_t3 && addr == 3) return TR;
        if (id == 3 && (addr % 5) == 0) return TR;
        if (id == 1) return 24'(addr);
        return {8'(id), 2'b00, 14'(addr)};
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < NI; i++) begin
            rom_data[i*24 +: 24] <= rom_word(i, int'(rom_addr[i*AW +: AW]));
        end
        if (ovf) ovf_cnt <= ovf_cnt + 1;
        if (rom_addr != '0) addr_cnt <= addr_cnt + 1;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mk(int x, int y, int dim, int id);
        return {7'(dim), 5'(id), 10'(y), 10'(x)};
    endfunction

    // Scan sprites in priority order; the first opaque texel covering (line,h) wins.
    function automatic logic [23:0] exp_px(logic [32*NS-1:0] a, int line, int h);
        logic [31:0] w;
        int dim, id, y, x;
        logic [23:0] t;
        if (h >= HA) return 24'd0;
        if (line < 0) return BG;
        for (int k = 0; k < NS; k++) begin
            w   = a[k*32 +: 32];
            dim = int'(w[31:25]);
            id  = int'(w[24:20]);
            y   = int'(w[19:10]);
            x   = int'(w[9:0]);
            if (dim == 0 || id >= NI) continue;
            if (line < y || line > y + dim - 1) continue;
            if (h < x || h > x + dim - 1) continue;
            t = rom_word(id, (line - y) * dim + (h - x));
            if (t != TR) return t;
        end
        return BG;
    endfunction

    task automatic model_step(int v);
        int t;
        shown_attr = pend_attr;
        shown_line = pend_line;
        pend_attr  = sprite_attr;
        t          = (v == VT - 1) ? 0 : v + 1;
        pend_line  = (t < VA) ? t : -1;
    endtask

    task automatic goto_line(int v, int n);
        @(negedge clk);
        vc = 10'(v);
        model_step(v);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_val(string tag, logic [31:0] o, logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic chk_px_exp(int h, logic [23:0] e, string tag);
        logic [23:0] o;
        @(negedge clk);
        hc = 10'(h);
        @(negedge clk);
        o = {vga_r, vga_g, vga_b};
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s line=%0d h=%0d observed=%06h expected=%06h", tag, shown_line, h, o, e);
        end
    endtask

    task automatic chk_px(int h, string tag);
        chk_px_exp(h, exp_px(shown_attr, shown_line, h), tag);
    endtask

    task automatic set_spr(int k, logic [31:0] w);
        sprite_attr[k*32 +: 32] = w;
    endtask

    initial begin
        int base, k, h, dim;
        logic [31:0] w;
        reset       = 1'b0;
        sprite_attr = '0;
        hc          = '0;
        vc          = '0;
        shown_attr  = '0;
        pend_attr   = '0;
        shown_line  = -1;
        pend_line   = -1;
        repeat (3) @(negedge clk);
        chk_val("reset_rgb", 32'({vga_r, vga_g, vga_b}), 32'd0);
        chk_val("reset_rom_addr", 32'(rom_addr != '0), 32'd0);
        chk_val("reset_ovf", 32'(ovf), 32'd0);
        reset = 1'b1;

        // Single sprite, two consecutive rows
        set_spr(0, mk(100, 50, 16, 1));
        goto_line(49, 200);
        goto_line(50, 200);
        chk_px(100, "t1_l50_c100");
        chk_px(101, "t1_l50_c101");
        chk_px(115, "t1_l50_c115");
        goto_line(51, 200);
        chk_px_exp(115, 24'd31, "t1_l51_c115");
        chk_px_exp(116, BG, "t1_l51_c116");
        chk_px(99, "t1_l51_c99");

        // Priority and transparency fall-through
        sprite_attr = '0;
        set_spr(0, mk(200, 60, 8, 1));
        set_spr(1, mk(200, 60, 8, 2));
        goto_line(59, 200);
        goto_line(60, 200);
        chk_px_exp(203, 24'd3, "t2_prio_c203");
        chk_px(207, "t2_prio_c207");
        chk_px(208, "t2_prio_c208");
        rom1_t3 = 1'b1;
        goto_line(59, 200);
        goto_line(60, 200);
        chk_px_exp(203, {8'd2, 2'b00, 14'd3}, "t2_transp_c203");
        chk_px(202, "t2_transp_c202");
        rom1_t3 = 1'b0;

        // Right-edge clipping
        sprite_attr = '0;
        set_spr(0, mk(630, 70, 16, 2));
        goto_line(69, 200);
        goto_line(70, 200);
        chk_px(630, "t3_c630");
        chk_px(635, "t3_c635");
        chk_px(639, "t3_c639");
        chk_px_exp(0, BG, "t3_c0");
        chk_px_exp(5, BG, "t3_c5");
        chk_px_exp(640, 24'd0, "t3_c640");
        chk_px_exp(700, 24'd0, "t3_c700");

        // Disabled sprites issue no ROM addresses and draw nothing
        sprite_attr = '0;
        set_spr(0, mk(10, 80, 0, 1));
        set_spr(1, mk(20, 80, 8, NI));
        set_spr(2, mk(30, 80, 8, 31));
        base = addr_cnt;
        goto_line(79, 200);
        goto_line(80, 200);
        chk_val("t5_no_rom_addr", 32'(addr_cnt - base), 32'd0);
        chk_px_exp(10, BG, "t5_dim0");
        chk_px_exp(22, BG, "t5_bad_id");

        // Vertical wrap: line V_TOTAL-1 renders line 0
        sprite_attr = '0;
        set_spr(0, mk(300, 0, 10, 2));
        goto_line(523, 200);
        goto_line(524, 200);
        chk_px_exp(300, BG, "t5_blank_line524");
        goto_line(0, 200);
        chk_px(300, "t5_wrap_c300");
        chk_px(309, "t5_wrap_c309");
        chk_px_exp(310, BG, "t5_wrap_c310");

        // Overflow: 16 large sprites on one row with a 1600-clk line
        sprite_attr = '0;
        for (int s = 0; s < NS; s++) set_spr(s, mk(40 * s, 100, 127, s % 4));
        goto_line(98, 200);
        base = ovf_cnt;
        goto_line(99, 1600);
        for (int s = 1; s < NS; s++) set_spr(s, 32'd0);
        goto_line(100, 200);
        chk_val("t4_ovf_once", 32'(ovf_cnt - base), 32'd1);
        for (int s = 0; s < 12; s++) chk_px(40 * s + 101, "t4_drawn");
        chk_px_exp(621, BG, "t4_dropped_s13");
        goto_line(101, 200);
        chk_px(101, "t4_next_c101");
        chk_px_exp(621, BG, "t4_next_c621");
        chk_px(300, "t4_next_c300");
        chk_val("t4_ovf_total", 32'(ovf_cnt - base), 32'd1);

        // Randomized sprite sets against the model
        for (int round = 0; round < 6; round++) begin
            sprite_attr = '0;
            for (int s = 0; s < NS; s++) begin
                set_spr(s, mk($urandom_range(0, 650), $urandom_range(190, 205),
                              $urandom_range(0, 20), $urandom_range(0, 5)));
            end
            goto_line(204, 400);
            goto_line(205, 20);
            for (int j = 0; j < 6; j++) begin
                k   = $urandom_range(0, NS - 1);
                w   = sprite_attr[k*32 +: 32];
                dim = int'(w[31:25]);
                h   = int'(w[9:0]) + $urandom_range(0, dim);
                if (h > 700) h = $urandom_range(0, HA - 1);
                chk_px(h, "rand_sprite");
            end
            chk_px($urandom_range(0, HA - 1), "rand_col");
        end

        // Asynchronous reset in the middle of a fetch
        sprite_attr = '0;
        set_spr(0, mk(50, 300, 100, 1));
        goto_line(299, 200);
        goto_line(300, 200);
        chk_px(150, "t6_pre_c150");
        goto_line(301, 20);
        chk_px(60, "t6_pre_c60");
        @(negedge clk);
        #1 reset = 1'b0;
        #1;
        chk_val("t6_async_rgb", 32'({vga_r, vga_g, vga_b}), 32'd0);
        chk_val("t6_async_rom_addr", 32'(rom_addr != '0), 32'd0);
        repeat (3) @(negedge clk);
        chk_val("t6_reset_ovf", 32'(ovf), 32'd0);
        pend_line  = -1;
        shown_line = -1;
        reset      = 1'b1;
        model_step(301);
        repeat (200) @(negedge clk);
        chk_px_exp(60, BG, "t6_first_line_bg");
        goto_line(302, 200);
        chk_px(60, "t6_second_c60");
        chk_px(149, "t6_second_c149");
        chk_px_exp(150, BG, "t6_second_c150");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
